// File: rtl/int_issue_queue_pkg.sv
// Shared integer-pipeline definitions: instruction payload, CDB broadcast, tag width,
// opcode constants, the issue-queue slot record and the CDB operand wake-up helper.
package int_issue_queue_pkg;

  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LUI_TYPE    = 7'b0110111;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
  } int_fifo_data;

  typedef struct packed {
    logic             cdb_valid;
    logic             cdb_branch;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_result;
  } cdb_bfm;

  typedef struct packed {
    logic             valid;
    logic             rs1_rdy;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    int_fifo_data     data;
  } iq_slot_t;

  // Capture the broadcast result into every still-waiting operand whose producer tag matches.
  function automatic iq_slot_t cdb_wake(input iq_slot_t s, input cdb_bfm c);
    iq_slot_t r;
    r = s;
    if (s.valid && c.cdb_valid) begin
      if (!s.rs1_rdy && (s.rs1_tag == c.cdb_tag)) begin
        r.rs1_rdy       = 1'b1;
        r.data.rs1_data = c.cdb_result;
      end else begin
        r.rs1_rdy = s.rs1_rdy;
      end
      if (!s.rs2_rdy && (s.rs2_tag == c.cdb_tag)) begin
        r.rs2_rdy       = 1'b1;
        r.data.rs2_data = c.cdb_result;
      end else begin
        r.rs2_rdy = s.rs2_rdy;
      end
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_issue_queue_entry.sv
// One reservation slot: holds valid, operand tags/ready bits and payload, and presents
// its post-wake-up view so the queue can compact and wake in the same edge.
module iq_entry
  import int_issue_queue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  cdb_bfm       cdb,
  input  iq_slot_t     slot_d,
  output iq_slot_t     slot_wk,
  output logic         issue_rdy,
  output int_fifo_data cur_data
);

  iq_slot_t slot_q;
  logic     unused_cdb_branch;

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Wake-up view used for next-state; eligibility uses the registered bits only.
  always_comb begin
    slot_wk = cdb_wake(slot_q, cdb);
  end

  assign issue_rdy         = slot_q.valid & slot_q.rs1_rdy & slot_q.rs2_rdy;
  assign cur_data          = slot_q.data;
  assign unused_cdb_branch = cdb.cdb_branch;

endmodule

// File: rtl/int_issue_queue.sv
// Age-ordered integer issue queue (slot 0 oldest) with CDB wake-up and compaction.
// Define INT_IQ_BYPASS_EN to wake operands from the CDB in their dispatch cycle.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  input  int_fifo_data               disp_data,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  cdb_bfm                     cdb,
  input  logic                       flush,
  output logic                       iq_full,
  output logic [$clog2(DEPTH+1)-1:0] iq_count,
  output logic                       issue_req,
  input  logic                       issue_granted,
  output int_fifo_data               int_exec_fifo_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iq_slot_t     slot_d   [DEPTH];
  iq_slot_t     wk_ext   [DEPTH+1];
  int_fifo_data cur_data [DEPTH];
  logic [DEPTH-1:0] rdy_vec;

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic             remove_s;
  logic             accept_s;
  iq_slot_t         new_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .cdb       (cdb),
      .slot_d    (slot_d[g]),
      .slot_wk   (wk_ext[g]),
      .issue_rdy (rdy_vec[g]),
      .cur_data  (cur_data[g])
    );
  end

  // Empty slot shifted into the youngest position on removal.
  assign wk_ext[DEPTH] = '0;

  // Occupancy and oldest-ready selection, both from registered state.
  always_comb begin
    cnt_s       = '0;
    sel_idx_s   = '0;
    sel_found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_s = cnt_s + CNT_W'(wk_ext[i].valid);
      if (rdy_vec[i] && !sel_found_s) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign iq_count           = cnt_s;
  assign iq_full            = (cnt_s == CNT_W'(DEPTH));
  assign issue_req          = sel_found_s;
  assign int_exec_fifo_data = sel_found_s ? cur_data[sel_idx_s] : '0;

  // Next slot contents: flush, then dispatch write, then compaction over the woken view.
  always_comb begin
    remove_s = sel_found_s & issue_granted;
    accept_s = disp_valid & ~iq_full;
    wr_idx_s = cnt_s - CNT_W'(remove_s);

    new_s         = '0;
    new_s.valid   = 1'b1;
    new_s.rs1_rdy = disp_rs1_rdy;
    new_s.rs2_rdy = disp_rs2_rdy;
    new_s.rs1_tag = disp_rs1_tag;
    new_s.rs2_tag = disp_rs2_tag;
    new_s.data    = disp_data;
`ifdef INT_IQ_BYPASS_EN
    new_s = cdb_wake(new_s, cdb);
`else
    new_s = new_s;
`endif

    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = '0;
      if (flush) begin
        slot_d[i] = '0;
      end else if (accept_s && (CNT_W'(i) == wr_idx_s)) begin
        slot_d[i] = new_s;
      end else if (remove_s && (IDX_W'(i) >= sel_idx_s)) begin
        slot_d[i] = wk_ext[i+1];
      end else begin
        slot_d[i] = wk_ext[i];
      end
    end
  end

endmodule
